// File: rtl/ecc_scalar_mult_seq.sv
// rtl/ecc_scalar_mult_seq.sv - MSB-first double-and-add scalar multiplication sequencer driving an external point unit.
// Optional constant-time schedule selected by defining CONST_TIME_EN.
module ecc_scalar_mult_seq #(
  parameter int WIDTH = 256,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] x_output,
  output logic [WIDTH-1:0] y_output,
  output logic             inf_out,
  output logic             pu_req,
  output logic             pu_op,
  output logic [WIDTH-1:0] pu_ax,
  output logic [WIDTH-1:0] pu_ay,
  output logic [WIDTH-1:0] pu_bx,
  output logic [WIDTH-1:0] pu_by,
  output logic             pu_ainf,
  input  logic             pu_ack,
  input  logic [WIDTH-1:0] pu_rx,
  input  logic [WIDTH-1:0] pu_ry,
  input  logic             pu_rinf
);

  typedef enum logic [2:0] {S_IDLE, S_BIT, S_DBL, S_ADD, S_FIN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc_x, acc_y, acc_x_nxt, acc_y_nxt;
  logic             acc_inf, acc_inf_nxt;
  logic [WIDTH-1:0] kr, pr_x, pr_y;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             kbit, step, accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      acc_x    <= '0;
      acc_y    <= '0;
      acc_inf  <= 1'b0;
      idx      <= '0;
      kr       <= '0;
      pr_x     <= '0;
      pr_y     <= '0;
      x_output <= '0;
      y_output <= '0;
      inf_out  <= 1'b0;
    end else begin
      state   <= state_nxt;
      acc_x   <= acc_x_nxt;
      acc_y   <= acc_y_nxt;
      acc_inf <= acc_inf_nxt;
      idx     <= idx_nxt;
      if (accept) begin
        kr   <= k;
        pr_x <= x1;
        pr_y <= y1;
      end
      // Load the result on entry to FIN so it is already valid while done is high.
      if (state_nxt == S_FIN) begin
        x_output <= acc_inf_nxt ? '0 : acc_x_nxt;
        y_output <= acc_inf_nxt ? '0 : acc_y_nxt;
        inf_out  <= acc_inf_nxt;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    acc_x_nxt   = acc_x;
    acc_y_nxt   = acc_y;
    acc_inf_nxt = acc_inf;
    idx_nxt     = idx;
    step        = 1'b0;
    accept      = 1'b0;
    kbit        = kr[idx];

    case (state)
      S_IDLE: begin
        if (start) begin
          accept      = 1'b1;
          acc_x_nxt   = '0;
          acc_y_nxt   = '0;
          acc_inf_nxt = 1'b1;
          idx_nxt     = IDX_W'(WIDTH - 1);
          state_nxt   = S_BIT;
        end
      end
      S_BIT: begin
`ifdef CONST_TIME_EN
        state_nxt = S_DBL;
`else
        if (acc_inf) begin
          // Leading zeros and the first set bit never need the point unit.
          if (kbit) begin
            acc_x_nxt   = pr_x;
            acc_y_nxt   = pr_y;
            acc_inf_nxt = 1'b0;
          end
          step = 1'b1;
        end else begin
          state_nxt = S_DBL;
        end
`endif
      end
      S_DBL: begin
        if (pu_ack) begin
          acc_x_nxt   = pu_rx;
          acc_y_nxt   = pu_ry;
          acc_inf_nxt = pu_rinf;
`ifdef CONST_TIME_EN
          state_nxt = S_ADD;
`else
          if (kbit && !pu_rinf) begin
            state_nxt = S_ADD;
          end else if (kbit) begin
            acc_x_nxt   = pr_x;
            acc_y_nxt   = pr_y;
            acc_inf_nxt = 1'b0;
            step        = 1'b1;
          end else begin
            step = 1'b1;
          end
`endif
        end
      end
      S_ADD: begin
        if (pu_ack) begin
`ifdef CONST_TIME_EN
          if (kbit) begin
            acc_x_nxt   = pu_rx;
            acc_y_nxt   = pu_ry;
            acc_inf_nxt = pu_rinf;
          end
`else
          acc_x_nxt   = pu_rx;
          acc_y_nxt   = pu_ry;
          acc_inf_nxt = pu_rinf;
`endif
          step = 1'b1;
        end
      end
      S_FIN: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    if (step) begin
      if (idx == '0) begin
        state_nxt = S_FIN;
      end else begin
        idx_nxt   = idx - IDX_W'(1);
        state_nxt = S_BIT;
      end
    end

    busy   = (state != S_IDLE);
    done   = (state == S_FIN);
    pu_req = (state == S_DBL) || (state == S_ADD);
    pu_op  = (state == S_ADD);
    pu_ax  = acc_x;
    pu_ay  = acc_y;
    pu_bx  = pr_x;
    pu_by  = pr_y;
`ifdef CONST_TIME_EN
    pu_ainf = acc_inf;
`else
    pu_ainf = 1'b0;
`endif
  end

endmodule

// File: tb/tb_ecc_scalar_mult_seq.sv
// tb/tb_ecc_scalar_mult_seq.sv - randomized bench for ecc_scalar_mult_seq against a symbolic point-unit model.
module tb_ecc_scalar_mult_seq;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] k_in, x_in, y_in;
  logic         start8, start256;
  logic         sel256;
  int           n_wait;
  int           wait_cnt;

  logic         busy8, done8, inf8, req8, op8, ainf8, ack8, rinf8;
  logic [7:0]   xo8, yo8, ax8, ay8, bx8, by8, rx8, ry8;
  logic         busy256, done256, inf256, req256, op256, ainf256, ack256, rinf256;
  logic [255:0] xo256, yo256, ax256, ay256, bx256, by256, rx256, ry256;

  logic         busy, done, inf_o, req, op, ainf, ack, rinf;
  logic [255:0] xo, yo, ax, ay, bx, by, rx, ry, mask;

  int           n_vec = 0;
  int           n_err = 0;
  int           req_cnt = 0;
  int           stab_err = 0;
  logic         pending = 1'b0;
  logic [1026:0] saved = '0;

  always #5 clk = ~clk;

  ecc_scalar_mult_seq #(.WIDTH(8), .IDX_W(3)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .k(k_in[7:0]), .x1(x_in[7:0]), .y1(y_in[7:0]),
    .busy(busy8), .done(done8), .x_output(xo8), .y_output(yo8), .inf_out(inf8),
    .pu_req(req8), .pu_op(op8), .pu_ax(ax8), .pu_ay(ay8), .pu_bx(bx8), .pu_by(by8),
    .pu_ainf(ainf8), .pu_ack(ack8), .pu_rx(rx8), .pu_ry(ry8), .pu_rinf(rinf8)
  );

  ecc_scalar_mult_seq #(.WIDTH(256), .IDX_W(8)) dut256 (
    .clk(clk), .reset(reset), .start(start256), .k(k_in), .x1(x_in), .y1(y_in),
    .busy(busy256), .done(done256), .x_output(xo256), .y_output(yo256), .inf_out(inf256),
    .pu_req(req256), .pu_op(op256), .pu_ax(ax256), .pu_ay(ay256), .pu_bx(bx256), .pu_by(by256),
    .pu_ainf(ainf256), .pu_ack(ack256), .pu_rx(rx256), .pu_ry(ry256), .pu_rinf(rinf256)
  );

  // Route whichever instance is under test onto one set of wide signals.
  assign busy  = sel256 ? busy256 : busy8;
  assign done  = sel256 ? done256 : done8;
  assign inf_o = sel256 ? inf256  : inf8;
  assign req   = sel256 ? req256  : req8;
  assign op    = sel256 ? op256   : op8;
  assign ainf  = sel256 ? ainf256 : ainf8;
  assign xo    = sel256 ? xo256 : {248'b0, xo8};
  assign yo    = sel256 ? yo256 : {248'b0, yo8};
  assign ax    = sel256 ? ax256 : {248'b0, ax8};
  assign ay    = sel256 ? ay256 : {248'b0, ay8};
  assign bx    = sel256 ? bx256 : {248'b0, bx8};
  assign by    = sel256 ? by256 : {248'b0, by8};
  assign mask  = sel256 ? {256{1'b1}} : {248'b0, 8'hff};

  // Symbolic point unit: double = 2A, add = A+B (B when A is infinity).
  assign ack   = req && (wait_cnt == n_wait);
  assign rx    = (op ? (ainf ? bx : ax + bx) : (ax << 1)) & mask;
  assign ry    = (op ? (ainf ? by : ay + by) : (ay << 1)) & mask;
  assign rinf  = !op && ainf;
  assign ack8   = !sel256 && ack;
  assign ack256 = sel256 && ack;
  assign rx8    = rx[7:0];
  assign ry8    = ry[7:0];
  assign rinf8  = rinf;
  assign rx256  = rx;
  assign ry256  = ry;
  assign rinf256 = rinf;

  always @(posedge clk or posedge reset) begin
    if (reset)    wait_cnt <= 0;
    else if (req) wait_cnt <= ack ? 0 : wait_cnt + 1;
    else          wait_cnt <= 0;
  end

  always @(negedge clk) begin
    if (req) begin
      if (pending && ({op, ainf, ax, ay, bx, by} != saved)) stab_err <= stab_err + 1;
      saved   <= {op, ainf, ax, ay, bx, by};
      pending <= !ack;
      if (ack) req_cnt <= req_cnt + 1;
    end else begin
      pending <= 1'b0;
    end
  end

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_mult(input logic [255:0] kk, input logic [255:0] xx, input logic [255:0] yy,
                          input int nn, input bit wide, input bit repulse, input string tag,
                          output int cyc);
    int w, msb, pop, ereq, ecyc, r0, s0, busy_bad;
    logic [255:0] m, ek, ex, ey;
    w  = wide ? 256 : 8;
    m  = wide ? {256{1'b1}} : {248'b0, 8'hff};
    ek = kk & m;
    ex = (ek * (xx & m)) & m;
    ey = (ek * (yy & m)) & m;
    msb = -1;
    pop = 0;
    for (int b = 0; b < w; b++) if (ek[b]) begin msb = b; pop++; end
`ifdef CONST_TIME_EN
    ereq = 2 * w;
`else
    ereq = (msb < 0) ? 0 : msb + pop - 1;
`endif
    ecyc = 1 + w + ereq * (nn + 1);

    @(negedge clk);
    sel256 = wide;
    n_wait = nn;
    k_in = kk; x_in = xx; y_in = yy;
    r0 = req_cnt;
    s0 = stab_err;
    if (wide) start256 = 1'b1; else start8 = 1'b1;
    cyc = 0;
    busy_bad = 0;
    while (cyc < 20000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start8 = 1'b0;
      start256 = 1'b0;
      if (done) break;
      if (!busy) busy_bad++;
      if (repulse && cyc == 3) begin
        k_in = 256'd3;
        if (wide) start256 = 1'b1; else start8 = 1'b1;
      end
    end
    check_val({tag, "_cycles"}, cyc, ecyc);
    check_val({tag, "_x"}, xo, ex);
    check_val({tag, "_y"}, yo, ey);
    check_val({tag, "_inf"}, inf_o, ek == 0);
    check_val({tag, "_reqs"}, req_cnt - r0, ereq);
    check_val({tag, "_stable"}, stab_err - s0, 0);
    check_val({tag, "_busy"}, busy_bad, 0);
    @(posedge clk);
    @(negedge clk);
    check_val({tag, "_done_pulse"}, {busy, done}, 2'b00);
  endtask

  initial begin
    int c0, c1, guard;
    reset = 1'b1;
    start8 = 1'b0; start256 = 1'b0; sel256 = 1'b0; n_wait = 0;
    k_in = '0; x_in = '0; y_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel256 = s[0];
      #1;
      check_val("rst_ctrl", {busy, done, req, op, ainf, inf_o}, 6'b0);
      check_val("rst_xo", xo | yo, '0);
      check_val("rst_ops", ax | ay | bx | by, '0);
    end

    run_mult(256'd0, 256'd1, 256'd1, 2, 1'b0, 1'b0, "k0", c0);
    run_mult(256'd1, 256'd1, 256'd1, 0, 1'b0, 1'b0, "k1", c1);
    run_mult(256'd5, 256'd1, 256'd1, 3, 1'b0, 1'b0, "k5", c1);
    run_mult({256{1'b1}}, 256'd1, 256'd1, 1, 1'b1, 1'b0, "kmax", c1);
    run_mult(256'd200, 256'd1, 256'd1, 2, 1'b0, 1'b1, "repulse", c1);

    // Abort in the middle of a doubling.
    @(negedge clk);
    sel256 = 1'b0; n_wait = 5;
    k_in = 256'd200; x_in = 256'd1; y_in = 256'd1;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    guard = 0;
    while (!req && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_val("mid_req_seen", req, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_val("mid_rst_ctrl", {busy, req, done}, 3'b000);
    check_val("mid_rst_xo", xo, '0);
    @(negedge clk);
    reset = 1'b0;
    run_mult(256'd3, 256'd1, 256'd1, 1, 1'b0, 1'b0, "after_rst", c1);

    for (int r = 0; r < 8; r++)
      run_mult({224'b0, $urandom}, {224'b0, $urandom}, {224'b0, $urandom},
               int'($urandom_range(0, 3)), 1'b0, 1'b0, "rand8", c1);
    for (int r = 0; r < 2; r++)
      run_mult({8{$urandom}}, {8{$urandom}}, {8{$urandom}},
               int'($urandom_range(0, 1)), 1'b1, 1'b0, "rand256", c1);

`ifdef CONST_TIME_EN
    run_mult(256'd5, 256'd1, 256'd1, 1, 1'b0, 1'b0, "ct_k5", c0);
    run_mult(256'd0, 256'd1, 256'd1, 1, 1'b0, 1'b0, "ct_k0", c1);
    check_val("ct_same_cycles", c0, c1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
